multi_in_gates: RTL and testbench
=================================

MULTI_IN_GATES -- requirements
Module: multi_in_gates

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal range 2..8.
REQ-002 Parameter: TICK_DIV, default 12000000, clock cycles per sweep step (1 Hz at 12 MHz).
REQ-003 Parameter: DB_CNT, default 240000, cycles the mode key must stay stable to count as a press (20 ms).
REQ-004 Port: clk  input  1  system clock, all state on rising edge.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: a  input  WIDTH  switch inputs, asynchronous to clk.
REQ-007 Port: mode_key  input  1  push key, active-low, asynchronous, bouncy.
REQ-008 Port: led  output  6  registered gate results over cur_in.
REQ-009 Port: cur_in  output  WIDTH  operand currently evaluated.
REQ-010 Port: sweep  output  1  1 = sweep mode, 0 = manual mode.
REQ-011 Port: wrap  output  1  one-cycle pulse when the sweep operand wraps to 0.

Function
REQ-012 The block SHALL pass a and mode_key through two-flop synchronisers before any use.
REQ-013 led SHALL encode [0] AND, [1] OR, [2] NAND, [3] NOR, [4] XOR, [5] XNOR, each reduced over all WIDTH bits of cur_in.
REQ-014 led SHALL update one cycle after cur_in; no combinational path from any input to any output.
REQ-015 Manual mode: cur_in SHALL load synchronised a every cycle; an input change sampled at edge t reaches cur_in at edge t+2 and led at edge t+3.
REQ-016 Mode FSM SHALL have two states, MANUAL and SWEEP; each qualified key press toggles the state.
REQ-017 Entering SWEEP: cur_in and the prescaler SHALL clear to 0 in the toggle cycle.
REQ-018 In SWEEP, the prescaler SHALL count 0..TICK_DIV-1; at terminal count cur_in SHALL increment by 1 and the prescaler SHALL return to 0.
REQ-019 At terminal count with cur_in = 2^WIDTH-1, cur_in SHALL wrap to 0 and wrap SHALL be 1 for exactly that one cycle.
REQ-020 Leaving SWEEP: the prescaler SHALL hold at 0 and cur_in SHALL resume loading synchronised a on the next cycle.
REQ-021 A key press in the same cycle as a sweep terminal count SHALL take priority: mode toggles, cur_in does not increment, wrap stays 0.
REQ-022 A held key SHALL produce exactly one toggle; release generates no event.

Reset
REQ-023 On rst_n low, all flops SHALL clear asynchronously: sweep=0 (MANUAL), cur_in=0, prescaler=0, debounce counter=0, wrap=0, synchronisers=1 for mode_key and 0 for a.
REQ-024 On reset, led SHALL be 6'b101100, the gate results for operand 0.
REQ-025 Reset asserted mid-sweep SHALL abort the sweep immediately; after release the block starts in MANUAL.
REQ-026 Reset release SHALL be taken synchronously; first state change no earlier than the first rising clk edge after rst_n rises.

Configuration
REQ-027 Macro MULTI_IN_GATES_DEBOUNCE_EN defined: a press SHALL qualify only after synchronised mode_key is low for DB_CNT consecutive cycles; any high sample restarts the count.
REQ-028 Macro undefined: a press SHALL qualify on the first low sample of synchronised mode_key after a high sample; DB_CNT is ignored and no debounce counter is built.

Verification (WIDTH=4, TICK_DIV=4, DB_CNT=8, macro defined unless stated)
REQ-029 Manual: a=4'b1111 -> led=6'b100011 three cycles later; a=4'b0001 -> led=6'b010110 three cycles later; cur_in tracks a.
REQ-030 Key low for 10 cycles -> sweep=1, cur_in=0, cur_in steps every 4 cycles; after 64 cycles cur_in=0 with exactly one wrap pulse; led matches the REQ-013 encoding of each cur_in.
REQ-031 Key bounce: low 3, high 2, low 3 cycles -> sweep stays 0; then low 9 cycles -> exactly one toggle.
REQ-032 Press qualifies on a prescaler terminal count with cur_in=4'b0111 -> sweep=0, no increment to 4'b1000, wrap=0.
REQ-033 rst_n low mid-sweep at cur_in=4'b1010 -> before the next clk edge: cur_in=0, sweep=0, wrap=0, led=6'b101100.
REQ-034 Macro undefined: a single-cycle low pulse on mode_key -> one toggle, two cycles after the pulse is sampled.

Source files
------------

// File: rtl/multi_in_gates.sv
// multi_in_gates: six reduction gates (AND, OR, NAND, NOR, XOR, XNOR) over
// one WIDTH-bit operand. The operand comes either from the switches (manual
// mode) or from a free-running sweep counter (sweep mode). A push key toggles
// between the two modes.
//
// Build option: define MULTI_IN_GATES_DEBOUNCE_EN to qualify key presses with
// a DB_CNT-cycle stability counter. Without it, a press is the first low
// sample of the synchronised key after a high sample, and no counter is built.
//
// Mode handshake: there is no valid/ready pair on this block. The mode key is
// a level input that is synchronised and turned into a one-cycle 'press'
// strobe. Each press is consumed in the cycle it is raised and cannot stall.
// The 'sweep' output is the mode FSM state itself (0 = MANUAL, 1 = SWEEP), so
// the FSM can be observed directly from outside.
module multi_in_gates #(
  parameter int WIDTH    = 4,
  parameter int TICK_DIV = 12000000,
  parameter int DB_CNT   = 240000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic             mode_key,
  output logic [5:0]       led,
  output logic [WIDTH-1:0] cur_in,
  output logic             sweep,
  output logic             wrap
);

  typedef enum logic {
    MANUAL = 1'b0,
    SWEEP  = 1'b1
  } mode_t;

  // Prescaler width; keep at least one bit so TICK_DIV = 1 still elaborates.
  localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] OPER_MAX  = '1;
  // Gate results for operand 0: XNOR=1, XOR=0, NOR=1, NAND=1, OR=0, AND=0.
  localparam logic [5:0]      LED_ZERO   = 6'b101100;

  // --------------------------------------------------------------------------
  // Input synchronisers. The key idles high (released), so its flops reset to
  // 1. This keeps reset release from looking like a press.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] a_meta;
  logic [WIDTH-1:0] a_sync;
  logic             key_meta;
  logic             key_sync;

  // Two-flop synchronisers for the switches and the key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_meta   <= '0;
      a_sync   <= '0;
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      a_meta   <= a;
      a_sync   <= a_meta;
      key_meta <= mode_key;
      key_sync <= key_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Press qualification. 'press' is high for exactly one cycle per key press.
  // --------------------------------------------------------------------------
  logic press;

`ifdef MULTI_IN_GATES_DEBOUNCE_EN
  localparam int            DW      = $clog2(DB_CNT + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CNT - 1);
  localparam logic [DW-1:0] DB_FULL = DW'(DB_CNT);

  logic [DW-1:0] db_cnt;

  // Count consecutive low samples. Any high sample restarts the count. The
  // counter saturates at DB_CNT, so a held key fires only once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
    end else if (key_sync) begin
      db_cnt <= '0;
    end else if (db_cnt != DB_FULL) begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // The DB_CNT-th consecutive low sample is the press.
  assign press = ~key_sync & (db_cnt == DB_LAST);
`else
  logic key_prev;

  // Previous synchronised key level, used for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_prev <= 1'b1;
    end else begin
      key_prev <= key_sync;
    end
  end

  // First low sample after a high one. Releasing the key produces no event.
  assign press = ~key_sync & key_prev;

  // DB_CNT has no role in this build.
  logic unused_db;
  assign unused_db = (DB_CNT != 0);
`endif

  // --------------------------------------------------------------------------
  // Mode FSM.
  // --------------------------------------------------------------------------
  mode_t state;
  mode_t state_nxt;

  // Mode state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MANUAL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next mode: every qualified press flips the mode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      MANUAL: if (press) state_nxt = SWEEP;
      SWEEP:  if (press) state_nxt = MANUAL;
      default: state_nxt = MANUAL;
    endcase
  end

  assign sweep = (state == SWEEP);

  // --------------------------------------------------------------------------
  // Operand path: prescaler, operand register and wrap strobe.
  // --------------------------------------------------------------------------
  logic [PW-1:0]    presc;
  logic [PW-1:0]    presc_nxt;
  logic [WIDTH-1:0] cur_nxt;
  logic             wrap_nxt;
  logic             tick;

  assign tick = (state == SWEEP) && (presc == PRESC_LAST);

  // Next operand and prescaler. A press outranks a sweep tick. In the toggle
  // cycle the operand either clears (entering sweep) or holds (leaving sweep).
  // Manual loading resumes on the cycle after leaving sweep.
  always_comb begin
    presc_nxt = '0;
    cur_nxt   = cur_in;
    wrap_nxt  = 1'b0;
    if (press) begin
      presc_nxt = '0;
      cur_nxt   = (state == MANUAL) ? '0 : cur_in;
    end else if (state == MANUAL) begin
      presc_nxt = '0;
      cur_nxt   = a_sync;
    end else if (tick) begin
      presc_nxt = '0;
      cur_nxt   = cur_in + 1'b1;
      wrap_nxt  = (cur_in == OPER_MAX);
    end else begin
      presc_nxt = presc + 1'b1;
      cur_nxt   = cur_in;
    end
  end

  // Operand, prescaler and wrap registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc  <= '0;
      cur_in <= '0;
      wrap   <= 1'b0;
    end else begin
      presc  <= presc_nxt;
      cur_in <= cur_nxt;
      wrap   <= wrap_nxt;
    end
  end

  // Registered gate results over the current operand, one cycle behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= LED_ZERO;
    end else begin
      led <= {~^cur_in, ^cur_in, ~|cur_in, ~&cur_in, |cur_in, &cur_in};
    end
  end

endmodule

// File: tb/tb_multi_in_gates.sv
// Bench for multi_in_gates (WIDTH=4, TICK_DIV=4, DB_CNT=8). The driver issues
// directed vectors and queues the expected value of one output at a given
// cycle. A negedge monitor pops and compares the entries that fall due.
module tb_multi_in_gates;

  localparam int K_LED   = 0;
  localparam int K_CUR   = 1;
  localparam int K_SWEEP = 2;
  localparam int K_WRAP  = 3;

`ifdef MULTI_IN_GATES_DEBOUNCE_EN
  localparam int D = 10;  // key low at cycle c -> toggle at c+10
`else
  localparam int D = 3;   // key low at cycle c -> toggle at c+3
`endif

  typedef struct {
    int         due;
    int         kind;
    logic [7:0] exp;
    string      name;
  } chk_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic       mode_key;
  logic [5:0] led;
  logic [3:0] cur_in;
  logic       sweep;
  logic       wrap;

  chk_t       exp_q[$];
  int         cyc;
  int         checks;
  int         failures;
  int         wrap_seen;
  logic [5:0] led_tab[16];

  multi_in_gates #(
    .WIDTH   (4),
    .TICK_DIV(4),
    .DB_CNT  (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .mode_key(mode_key),
    .led     (led),
    .cur_in  (cur_in),
    .sweep   (sweep),
    .wrap    (wrap)
  );

  // Clock and reset-gated cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) if (rst_n) cyc <= cyc + 1;

  task automatic push(input int kind, input int due, input logic [7:0] exp, input string name);
    chk_t e;
    e.due  = due;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare every entry due in the current cycle.
  initial begin
    checks    = 0;
    failures  = 0;
    wrap_seen = 0;
    forever begin
      @(negedge clk);
      if (wrap === 1'b1) wrap_seen++;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].due == cyc) begin
          logic [7:0] act;
          case (exp_q[i].kind)
            K_LED:   act = {2'b00, led};
            K_CUR:   act = {4'b0000, cur_in};
            K_SWEEP: act = {7'b0000000, sweep};
            default: act = {7'b0000000, wrap};
          endcase
          checks++;
          if (act !== exp_q[i].exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", exp_q[i].name, cyc, act, exp_q[i].exp);
          end
          exp_q.delete(i);
        end
      end
    end
  end

  // Driver: directed vectors.
  initial begin
    int c;
    int t;
    int t2;

    // Hand-computed gate results, bit order {XNOR,XOR,NOR,NAND,OR,AND}.
    led_tab[0]  = 6'b101100; led_tab[1]  = 6'b010110;
    led_tab[2]  = 6'b010110; led_tab[3]  = 6'b100110;
    led_tab[4]  = 6'b010110; led_tab[5]  = 6'b100110;
    led_tab[6]  = 6'b100110; led_tab[7]  = 6'b010110;
    led_tab[8]  = 6'b010110; led_tab[9]  = 6'b100110;
    led_tab[10] = 6'b100110; led_tab[11] = 6'b010110;
    led_tab[12] = 6'b100110; led_tab[13] = 6'b010110;
    led_tab[14] = 6'b010110; led_tab[15] = 6'b100011;

    rst_n    = 1'b0;
    a        = 4'h0;
    mode_key = 1'b1;

    // Reset state.
    push(K_LED,   0, 8'b00101100, "rst_led");
    push(K_CUR,   0, 8'h00,       "rst_cur_in");
    push(K_SWEEP, 0, 8'h00,       "rst_sweep");
    push(K_WRAP,  0, 8'h00,       "rst_wrap");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step(2);

    // Manual mode: cur_in 3 cycles and led 4 cycles after the input is set.
    a = 4'b1111; c = cyc;
    push(K_CUR,   c + 2, 8'h00,       "man_f_cur_early");
    push(K_CUR,   c + 3, 8'h0f,       "man_f_cur");
    push(K_LED,   c + 3, 8'b00101100, "man_f_led_early");
    push(K_LED,   c + 4, 8'b00100011, "man_f_led");
    push(K_SWEEP, c + 4, 8'h00,       "man_sweep");
    step(5);
    a = 4'b0001; c = cyc;
    push(K_CUR, c + 3, 8'h01,       "man_1_cur");
    push(K_LED, c + 3, 8'b00100011, "man_1_led_early");
    push(K_LED, c + 4, 8'b00010110, "man_1_led");
    step(5);
    a = 4'b0110; c = cyc;
    push(K_CUR, c + 3, 8'h06,       "man_6_cur");
    push(K_LED, c + 4, 8'b00100110, "man_6_led");
    step(5);
    a = 4'b0101;
    step(4);

    // Enter sweep: key low for 10 cycles.
    mode_key = 1'b0; c = cyc; t = c + D;
    push(K_SWEEP, t - 1, 8'h00, "sw_enter_early");
    push(K_SWEEP, t,     8'h01, "sw_enter");
    push(K_CUR,   t - 1, 8'h05, "sw_pre_cur");
    for (int k = 0; k <= 16; k++) begin
      push(K_CUR, t + 4 * k, 8'(k % 16), "sw_step_cur");
      push(K_LED, t + 4 * k + 1, {2'b00, led_tab[k % 16]}, "sw_step_led");
      if (k < 16) push(K_CUR, t + 4 * k + 3, 8'(k), "sw_hold_cur");
    end
    push(K_WRAP, t + 63, 8'h00, "sw_wrap_before");
    push(K_WRAP, t + 64, 8'h01, "sw_wrap");
    push(K_WRAP, t + 65, 8'h00, "sw_wrap_after");
    step(10);
    mode_key = 1'b1;
    a = 4'b1100;

    // Press landing on the terminal count with cur_in = 0111.
    step(t + 96 - D - cyc);
    mode_key = 1'b0;
    push(K_CUR,   t + 95, 8'h07,       "pri_cur_before");
    push(K_SWEEP, t + 95, 8'h01,       "pri_sweep_before");
    push(K_SWEEP, t + 96, 8'h00,       "pri_sweep");
    push(K_CUR,   t + 96, 8'h07,       "pri_no_incr");
    push(K_WRAP,  t + 96, 8'h00,       "pri_wrap");
    push(K_CUR,   t + 97, 8'h0c,       "pri_resume_cur");
    push(K_LED,   t + 98, 8'b00100110, "pri_resume_led");
    step(10);
    mode_key = 1'b1;
    step(5);

`ifdef MULTI_IN_GATES_DEBOUNCE_EN
    // Bounce: low 3, high 2, low 3 -> no toggle.
    mode_key = 1'b0; c = cyc;
    step(3); mode_key = 1'b1;
    step(2); mode_key = 1'b0;
    step(3); mode_key = 1'b1;
    push(K_SWEEP, c + 5,  8'h00, "bounce_a");
    push(K_SWEEP, c + 9,  8'h00, "bounce_b");
    push(K_SWEEP, c + 14, 8'h00, "bounce_c");
    step(12);
    // Low for 9 cycles -> exactly one toggle.
    mode_key = 1'b0; c = cyc; t2 = c + 10;
    push(K_SWEEP, t2 - 1,  8'h00, "db_toggle_early");
    push(K_SWEEP, t2,      8'h01, "db_toggle");
    push(K_SWEEP, t2 + 15, 8'h01, "db_single");
    step(9);
    mode_key = 1'b1;
`else
    // Single-cycle pulse -> one toggle two cycles after it is sampled.
    mode_key = 1'b0; c = cyc; t2 = c + 3;
    step(1);
    mode_key = 1'b1;
    push(K_SWEEP, c + 2,  8'h00, "pulse_toggle_early");
    push(K_SWEEP, t2,     8'h01, "pulse_toggle");
    push(K_SWEEP, c + 12, 8'h01, "pulse_single");
`endif

    // Reset in the middle of a sweep at cur_in = 1010.
    push(K_CUR,   t2 + 40, 8'h0a, "mid_cur");
    push(K_SWEEP, t2 + 40, 8'h01, "mid_sweep");
    step(t2 + 41 - cyc);
    rst_n = 1'b0;
    push(K_CUR,   cyc, 8'h00,       "arst_cur");
    push(K_SWEEP, cyc, 8'h00,       "arst_sweep");
    push(K_WRAP,  cyc, 8'h00,       "arst_wrap");
    push(K_LED,   cyc, 8'b00101100, "arst_led");
    step(2);
    rst_n = 1'b1;
    a = 4'b0111; c = cyc;
    push(K_CUR,   c + 2, 8'h00,       "post_rst_cur_early");
    push(K_CUR,   c + 3, 8'h07,       "post_rst_cur");
    push(K_SWEEP, c + 3, 8'h00,       "post_rst_sweep");
    push(K_LED,   c + 4, 8'b00010110, "post_rst_led");
    step(6);

    // Wrap count over the whole run.
    checks++;
    if (wrap_seen != 1) begin
      failures++;
      $display("FAIL wrap_count got=%0d exp=1", wrap_seen);
    end
    // Any entry still queued was never reached.
    foreach (exp_q[i]) begin
      checks++;
      failures++;
      $display("FAIL %s unchecked due=%0d now=%0d", exp_q[i].name, exp_q[i].due, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
